// File: rtl/vec_mul_pkg.sv
// Shared definitions for the vector-multiply sequencer: FSM state encoding
// and default array geometry.
package vec_mul_pkg;

  localparam int MATRIX_SIZE_DEF    = 64;
  localparam int ADDRESSSIZE_DEF    = 10;
  localparam int PARTIAL_SUM_BW_DEF = 24;

  typedef enum logic [2:0] {
    IDLE,
    WLOAD,
    WLATCH,
    STREAM,
    WAIT_END,
    DRAIN,
    DONE
  } seq_state_t;

endpackage

// File: rtl/vec_mul_row_checker.sv
// Registered result-row comparator: compares the row returned one cycle after
// each result read and counts mismatching rows, saturating at 16'hFFFF.
module vec_mul_row_checker #(
  parameter int ROW_W = 1536
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             row_valid,
  input  logic [ROW_W-1:0] row_data,
  input  logic [ROW_W-1:0] row_expected,
  output logic [15:0]      mismatch_cnt
);

  // The SRAM answers one cycle after the read, so the strobe is delayed to
  // line up with the returned row.
  logic row_valid_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      row_valid_q  <= 1'b0;
      mismatch_cnt <= 16'd0;
    end else begin
      row_valid_q <= row_valid;
      if (row_valid_q && (row_data != row_expected) && (mismatch_cnt != 16'hFFFF))
        mismatch_cnt <= mismatch_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/vec_mul_sequencer.sv
// Tile sequencer for the systolic vector multiplier: weight pop/reload,
// activation streaming, end_ wait with timeout, result drain. Optional row
// checker enabled by defining VEC_MUL_SEQ_CHECK_EN.
module vec_mul_sequencer
  import vec_mul_pkg::*;
#(
  parameter int ADDRESSSIZE    = ADDRESSSIZE_DEF,
  parameter int MATRIX_SIZE    = MATRIX_SIZE_DEF,
  parameter int MAX_TILES      = 4,
  parameter int PARTIAL_SUM_BW = PARTIAL_SUM_BW_DEF,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [$clog2(MAX_TILES+1)-1:0]      num_tiles,
  input  logic                                fifo_empty,
  output logic                                fifo_read_enable,
  output logic                                weight_reload,
  output logic                                valid_address,
  output logic [ADDRESSSIZE-1:0]              sram_address,
  input  logic                                end_,
  output logic [ADDRESSSIZE-1:0]              result_address,
  output logic                                result_valid,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] sram_result_data_out,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] expected_data,
  output logic                                busy,
  output logic                                done,
  output logic                                timeout_err,
  output logic [15:0]                         mismatch_cnt
);

  localparam int TW    = $clog2(MAX_TILES+1);
  localparam int IW    = $clog2(MATRIX_SIZE+3);
  localparam int CW    = $clog2(TIMEOUT_CYCLES+1);
  localparam int ROW_W = PARTIAL_SUM_BW*MATRIX_SIZE;

  localparam logic [IW-1:0] ROWS       = IW'(MATRIX_SIZE);
  localparam logic [IW-1:0] LAST_ROW   = IW'(MATRIX_SIZE-1);
  // Two idle cycles after the last drained row let the final compare land
  // in mismatch_cnt before done rises.
  localparam logic [IW-1:0] DRAIN_LAST = IW'(MATRIX_SIZE+2);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(TIMEOUT_CYCLES-1);

  seq_state_t             state;
  logic [TW-1:0]          tiles_q;
  logic [TW-1:0]          tile_q;
  logic [ADDRESSSIZE-1:0] tile_base;
  logic [IW-1:0]          idx;
  logic [CW-1:0]          wait_cnt;
  logic                   start_accept;

  assign start_accept = (state == IDLE) && start;

  // All outputs are registered: each strobe is set on the edge that decides
  // it, so the pop, the reload and the address stream follow back to back.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      tiles_q          <= '0;
      tile_q           <= '0;
      tile_base        <= '0;
      idx              <= '0;
      wait_cnt         <= '0;
      fifo_read_enable <= 1'b0;
      weight_reload    <= 1'b0;
      valid_address    <= 1'b0;
      sram_address     <= '0;
      result_valid     <= 1'b0;
      result_address   <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      timeout_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_accept) begin
            timeout_err <= 1'b0;
            busy        <= 1'b1;
            tiles_q     <= num_tiles;
            tile_q      <= '0;
            tile_base   <= '0;
            if (num_tiles == '0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= WLOAD;
            end
          end
        end
        WLOAD: begin
          if (!fifo_empty) begin
            fifo_read_enable <= 1'b1;
            state            <= WLATCH;
          end
        end
        WLATCH: begin
          fifo_read_enable <= 1'b0;
          weight_reload    <= 1'b1;
          idx              <= '0;
          state            <= STREAM;
        end
        STREAM: begin
          weight_reload <= 1'b0;
          valid_address <= 1'b1;
          sram_address  <= ADDRESSSIZE'(idx);
          if (idx == LAST_ROW) begin
            idx      <= '0;
            wait_cnt <= '0;
            state    <= WAIT_END;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        WAIT_END: begin
          valid_address <= 1'b0;
          sram_address  <= '0;
          if (end_) begin
            idx   <= '0;
            state <= DRAIN;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_err <= 1'b1;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        DRAIN: begin
          if (idx < ROWS) begin
            result_valid   <= 1'b1;
            result_address <= tile_base + ADDRESSSIZE'(idx);
          end else begin
            result_valid   <= 1'b0;
            result_address <= '0;
          end
          if (idx == DRAIN_LAST) begin
            idx <= '0;
            if ((tile_q + TW'(1)) == tiles_q) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              tile_q    <= tile_q + TW'(1);
              tile_base <= tile_base + ADDRESSSIZE'(MATRIX_SIZE);
              state     <= WLOAD;
            end
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VEC_MUL_SEQ_CHECK_EN
  vec_mul_row_checker #(
    .ROW_W(ROW_W)
  ) u_row_checker (
    .clk         (clk),
    .rst         (rst),
    .clr         (start_accept),
    .row_valid   (result_valid),
    .row_data    (sram_result_data_out),
    .row_expected(expected_data),
    .mismatch_cnt(mismatch_cnt)
  );
`else
  logic unused_rows;
  assign unused_rows  = ^{sram_result_data_out, expected_data};
  assign mismatch_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vec_mul_sequencer.sv
// Self-checking bench for vec_mul_sequencer: address/result scoreboards,
// weight pop/reload tracking, timeout, reset-mid-run and checker counting.
module tb_vec_mul_sequencer;

  localparam int AW = 10;
  localparam int MS = 64;
  localparam int MT = 4;
  localparam int PW = 24;
  localparam int TO = 100;
  localparam int DW = PW*MS;
  localparam int TW = $clog2(MT+1);

`ifdef VEC_MUL_SEQ_CHECK_EN
  localparam int MM_CORRUPT = 2;
`else
  localparam int MM_CORRUPT = 0;
`endif

  // clock / reset and DUT signals
  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [TW-1:0] num_tiles;
  logic          fifo_empty;
  logic          fifo_read_enable;
  logic          weight_reload;
  logic          valid_address;
  logic [AW-1:0] sram_address;
  logic          end_;
  logic [AW-1:0] result_address;
  logic          result_valid;
  logic [DW-1:0] sram_result_data_out = '0;
  logic [DW-1:0] expected_data = '0;
  logic          busy;
  logic          done;
  logic          timeout_err;
  logic [15:0]   mismatch_cnt;

  always #5 clk = ~clk;

  vec_mul_sequencer #(
    .ADDRESSSIZE   (AW),
    .MATRIX_SIZE   (MS),
    .MAX_TILES     (MT),
    .PARTIAL_SUM_BW(PW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .num_tiles           (num_tiles),
    .fifo_empty          (fifo_empty),
    .fifo_read_enable    (fifo_read_enable),
    .weight_reload       (weight_reload),
    .valid_address       (valid_address),
    .sram_address        (sram_address),
    .end_                (end_),
    .result_address      (result_address),
    .result_valid        (result_valid),
    .sram_result_data_out(sram_result_data_out),
    .expected_data       (expected_data),
    .busy                (busy),
    .done                (done),
    .timeout_err         (timeout_err),
    .mismatch_cnt        (mismatch_cnt)
  );

  // scoreboard state
  logic [AW-1:0] addr_exp_q[$];
  logic [AW-1:0] res_exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int pop_cnt = 0, reload_cnt = 0, done_cnt = 0, rv_cnt = 0;
  int pop0, reload0, done0, rv0;
  int gap = 0, last_gap = 0;
  logic prev_pop = 1'b0;
  logic auto_end = 1'b1;
  logic spurious_end = 1'b0;
  logic corrupt_en = 1'b0;
  int   end_delay = 5;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_row(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    for (int j = 0; j < MS; j++)
      r[j*PW +: PW] = (PW'(a) * PW'(MS) + PW'(j)) ^ 24'h5A5A00;
    return r;
  endfunction

  // result SRAM and golden model, one-cycle read latency
  always @(posedge clk) begin
    sram_result_data_out <= mk_row(result_address);
    expected_data <= mk_row(result_address) ^
      ((corrupt_en && (result_address == AW'(3) || result_address == AW'(40))) ? DW'(1) : DW'(0));
  end

  // array responder: end_ pulse end_delay cycles after the address stream
  initial begin
    int   pend;
    logic va_prev;
    pend = 0;
    va_prev = 1'b0;
    end_ = 1'b0;
    forever begin
      @(negedge clk);
      end_ = 1'b0;
      if (rst) begin
        pend = 0;
      end else begin
        if (spurious_end && valid_address && !va_prev) end_ = 1'b1;
        if (auto_end && va_prev && !valid_address) begin
          pend = end_delay;
        end else if (pend > 0) begin
          pend--;
          if (pend == 0) end_ = 1'b1;
        end
      end
      va_prev = valid_address;
    end
  end

  // output monitor
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (valid_address) begin
          e = (addr_exp_q.size() > 0) ? 32'(addr_exp_q.pop_front()) : 32'hFFFF_FFFF;
          chk("sram_address", 32'(sram_address), e);
        end
        if (result_valid) begin
          rv_cnt++;
          e = (res_exp_q.size() > 0) ? 32'(res_exp_q.pop_front()) : 32'hFFFF_FFFF;
          chk("result_address", 32'(result_address), e);
        end
        if (fifo_read_enable) begin
          pop_cnt++;
          chk("pop_while_empty", 32'(fifo_empty), 32'd0);
        end
        if (weight_reload) begin
          reload_cnt++;
          chk("reload_after_pop", 32'(prev_pop), 32'd1);
        end
        if (done) done_cnt++;
        if (valid_address) gap = 0;
        else begin
          gap++;
          if (done) last_gap = gap;
        end
        prev_pop = fifo_read_enable;
      end
    end
  end

  // driver tasks
  task automatic start_run(input int tiles, input int stream_tiles, input int drain_tiles);
    for (int t = 0; t < stream_tiles; t++)
      for (int i = 0; i < MS; i++) addr_exp_q.push_back(AW'(i));
    for (int t = 0; t < drain_tiles; t++)
      for (int i = 0; i < MS; i++) res_exp_q.push_back(AW'(t*MS + i));
    pop0 = pop_cnt; reload0 = reload_cnt; done0 = done_cnt; rv0 = rv_cnt;
    @(negedge clk);
    start = 1'b1;
    num_tiles = TW'(tiles);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_run(input int exp_tiles, input int exp_rows, input int exp_to, input int exp_mm);
    int n;
    n = 0;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", 32'(done), 32'd1);
    @(negedge clk);
    #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("done_count", 32'(done_cnt - done0), 32'd1);
    chk("fifo_pops", 32'(pop_cnt - pop0), 32'(exp_tiles));
    chk("weight_reloads", 32'(reload_cnt - reload0), 32'(exp_tiles));
    chk("result_rows", 32'(rv_cnt - rv0), 32'(exp_rows));
    chk("timeout_err", 32'(timeout_err), 32'(exp_to));
    chk("mismatch_cnt", 32'(mismatch_cnt), 32'(exp_mm));
    chk("addr_left", 32'(addr_exp_q.size()), 32'd0);
    chk("result_left", 32'(res_exp_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pop"}, 32'(fifo_read_enable), 32'd0);
    chk({tag, "_reload"}, 32'(weight_reload), 32'd0);
    chk({tag, "_valid_address"}, 32'(valid_address), 32'd0);
    chk({tag, "_sram_address"}, 32'(sram_address), 32'd0);
    chk({tag, "_result_valid"}, 32'(result_valid), 32'd0);
    chk({tag, "_result_address"}, 32'(result_address), 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    chk({tag, "_mismatch_cnt"}, 32'(mismatch_cnt), 32'd0);
  endtask

  initial begin
    int n, tiles, hold;
    rst = 1'b1;
    start = 1'b0;
    num_tiles = '0;
    fifo_empty = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // single tile, end_ five cycles after the stream
    start_run(1, 1, 1);
    finish_run(1, MS, 0, 0);

    // four tiles, matching golden rows
    start_run(4, 4, 4);
    finish_run(4, 4*MS, 0, 0);

    // weight FIFO empty for 10 cycles
    fifo_empty = 1'b1;
    start_run(1, 1, 1);
    repeat (10) @(negedge clk);
    chk("hold_no_pop", 32'(pop_cnt - pop0), 32'd0);
    chk("hold_no_reload", 32'(reload_cnt - reload0), 32'd0);
    chk("hold_busy", 32'(busy), 32'd1);
    fifo_empty = 1'b0;
    finish_run(1, MS, 0, 0);

    // end_ never arrives: abort after the first tile
    auto_end = 1'b0;
    start_run(2, 1, 0);
    finish_run(1, 0, 1, 0);
    chk("timeout_wait_cycles", 32'(last_gap), 32'(TO));
    auto_end = 1'b1;

    // corrupted golden rows 3 and 40
    corrupt_en = 1'b1;
    start_run(1, 1, 1);
    finish_run(1, MS, 0, MM_CORRUPT);
    corrupt_en = 1'b0;

    // zero tiles: done only
    start_run(0, 0, 0);
    finish_run(0, 0, 0, 0);

    // start and end_ outside their accepting states are ignored
    spurious_end = 1'b1;
    start_run(1, 1, 1);
    repeat (10) @(negedge clk);
    start = 1'b1;
    num_tiles = TW'(3);
    @(negedge clk);
    start = 1'b0;
    spurious_end = 1'b0;
    finish_run(1, MS, 0, 0);

    // reset in the middle of the address stream
    start_run(1, 1, 1);
    n = 0;
    while (!(valid_address && sram_address == AW'(20)) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("reached_addr20", 32'(sram_address), 32'd20);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("mid_reset");
    addr_exp_q.delete();
    res_exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    start_run(1, 1, 1);
    finish_run(1, MS, 0, 0);

    // randomised runs
    for (int k = 0; k < 3; k++) begin
      tiles = $urandom_range(1, MT);
      end_delay = $urandom_range(1, 20);
      hold = $urandom_range(0, 6);
      fifo_empty = (hold > 0);
      start_run(tiles, tiles, tiles);
      repeat (hold) @(negedge clk);
      fifo_empty = 1'b0;
      finish_run(tiles, tiles*MS, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
